// File: rtl/vin_pkg.sv
// Shared types and constants for the camera line framer.
package vin_pkg;

  localparam int unsigned VD_W = 80;
  localparam logic [15:0] TRL_MARKER = 16'hA55A;

  // Trailer field bit positions within the 80-bit word
  localparam int unsigned TRL_MARKER_LSB = 64;
  localparam int unsigned TRL_FRCNT_LSB  = 48;
  localparam int unsigned TRL_LINE_LSB   = 32;
  localparam int unsigned TRL_WORDS_LSB  = 16;
  localparam int unsigned TRL_OVF_BIT    = 15;
  localparam int unsigned TRL_TRUNC_BIT  = 14;
  localparam int unsigned TRL_SEC_LSB    = 0;
  localparam int unsigned TRL_SEC_W      = 12;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FRAME = 2'd1,
    W_LINE  = 2'd2,
    W_TRL   = 2'd3
  } wstate_t;

  // One FIFO entry: flags plus data or trailer payload
  typedef struct packed {
    logic            sof;
    logic            eol;
    logic [VD_W-1:0] data;
  } vin_word_t;

  typedef struct packed {
    logic [15:0]          marker;
    logic [15:0]          frcnt;
    logic [15:0]          line;
    logic [15:0]          words;
    logic                 ovf;
    logic                 trunc;
    logic [1:0]           rsvd;
    logic [TRL_SEC_W-1:0] sec;
  } vin_trailer_t;

  // Assemble a line trailer entry
  function automatic vin_word_t make_trailer(
    input logic [15:0]          frcnt,
    input logic [15:0]          line,
    input logic [15:0]          words,
    input logic                 ovf,
    input logic                 trunc,
    input logic [TRL_SEC_W-1:0] sec
  );
    vin_trailer_t t;
    vin_word_t    w;
    t.marker = TRL_MARKER;
    t.frcnt  = frcnt;
    t.line   = line;
    t.words  = words;
    t.ovf    = ovf;
    t.trunc  = trunc;
    t.rsvd   = 2'b00;
    t.sec    = sec;
    w.sof    = 1'b0;
    w.eol    = 1'b1;
    w.data   = t;
    return w;
  endfunction

endpackage

// File: rtl/vin_fifo_fwft.sv
// First-word-fall-through line FIFO with a registered output stage.
module vin_fifo_fwft
  import vin_pkg::*;
#(
  parameter int unsigned G_FIFO_AW = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  vin_word_t            wdata,
  input  logic                 rd,
  output vin_word_t            rdata,
  output logic                 empty,
  output logic                 full,
  output logic [G_FIFO_AW:0]   free
);

  localparam int unsigned DEPTH = 1 << G_FIFO_AW;
  localparam int unsigned CW    = G_FIFO_AW + 1;

  vin_word_t               mem [DEPTH];
  logic [G_FIFO_AW-1:0]    wr_ptr;
  logic [G_FIFO_AW-1:0]    rd_ptr;
  logic [CW-1:0]           mem_cnt;
  logic [CW-1:0]           occ;
  logic                    out_vld;
  vin_word_t               out_q;
  logic                    pop;
  logic                    load;
  logic                    bypass;
  logic                    mem_wr;
  logic                    mem_rd;

  // Total occupancy counts the output register as one entry
  assign occ   = mem_cnt + CW'(out_vld);
  assign full  = (occ == CW'(DEPTH));
  assign free  = CW'(DEPTH) - occ;
  assign empty = ~out_vld;
  assign rdata = out_q;

  // Route a write either straight into the output register or into the array
  always_comb begin
    pop    = out_vld & rd;
    load   = ~out_vld | pop;
    mem_rd = load & (mem_cnt != '0);
    bypass = load & wr & ~full & (mem_cnt == '0);
    mem_wr = wr & ~full & ~bypass;
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= wdata;
  end

  // Pointers, array count and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + G_FIFO_AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + G_FIFO_AW'(1);
      mem_cnt <= mem_cnt + CW'(mem_wr) - CW'(mem_rd);
      if (mem_rd) begin
        out_q   <= mem[rd_ptr];
        out_vld <= 1'b1;
      end else if (bypass) begin
        out_q   <= wdata;
        out_vld <= 1'b1;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vin_line_framer.sv
// Captures camera lines into a FIFO and appends a status trailer to each line.
module vin_line_framer
  import vin_pkg::*;
#(
  parameter int unsigned G_FIFO_AW  = 9,
  parameter int unsigned G_LINE_MAX = 160
) (
  input  logic            p_in_clk,
  input  logic            p_in_rst,
  input  logic [VD_W-1:0] p_in_vd,
  input  logic            p_in_vin_vs,
  input  logic            p_in_vin_hs,
  input  logic            p_in_ext_syn,
  input  logic            p_in_en,
  input  logic            p_in_ovf_clr,
  output logic [VD_W-1:0] p_out_vd,
  output logic            p_out_vd_vld,
  input  logic            p_in_vd_rdy,
  output logic            p_out_vd_sof,
  output logic            p_out_vd_eol,
  output logic [15:0]     p_out_frcnt,
  output logic            p_out_ovf
);

  localparam int unsigned CW = G_FIFO_AW + 1;

  wstate_t              state_q;
  wstate_t              state_d;
  logic                 vs_q;
  logic                 vs_low_seen;
  logic                 syn_q;
  logic [TRL_SEC_W-1:0] sec_cnt;
  logic [15:0]          frcnt;
  logic [15:0]          line_cnt;
  logic [15:0]          word_cnt;
  logic                 sof_pend;
  logic                 trunc_flag;
  logic                 lovf_flag;
  logic                 ovf_q;

  logic                 vs_rise;
  logic                 hs_word;
  logic                 line_full;
  logic                 space_ok;
  logic                 take_word;
  logic                 word_wr;
  logic                 word_trunc;
  logic                 word_ovf;
  logic                 trl_wr;
  logic                 trl_lost;
  logic                 trl_hs_drop;
  logic                 frame_start;
  logic                 frame_end;

  logic                 fifo_wr;
  vin_word_t            fifo_wdata;
  vin_word_t            fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CW-1:0]        fifo_free;

  // A vs level already high when reset releases is not treated as a frame start
  assign vs_rise   = p_in_vin_vs & ~vs_q & vs_low_seen;
  assign hs_word   = p_in_vin_hs & p_in_vin_vs;
  assign line_full = (word_cnt >= 16'(G_LINE_MAX));
  assign space_ok  = (fifo_free >= CW'(2));

  // Write FSM state register
  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) state_q <= W_IDLE;
    else          state_q <= state_d;
  end

  // Write FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (vs_rise & p_in_en) state_d = W_FRAME;
      W_FRAME: begin
        if (!p_in_vin_vs)     state_d = W_IDLE;
        else if (p_in_vin_hs) state_d = W_LINE;
      end
      W_LINE:  if (!hs_word) state_d = W_TRL;
      W_TRL:   state_d = p_in_vin_vs ? W_FRAME : W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: word accept/drop decisions and FIFO write data
  always_comb begin
    take_word   = 1'b0;
    word_wr     = 1'b0;
    word_trunc  = 1'b0;
    word_ovf    = 1'b0;
    trl_wr      = 1'b0;
    trl_hs_drop = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      W_IDLE:  frame_start = vs_rise & p_in_en;
      W_FRAME: begin
        frame_end = ~p_in_vin_vs;
        take_word = hs_word;
      end
      W_LINE:  take_word = hs_word;
      W_TRL: begin
        trl_wr      = 1'b1;
        frame_end   = ~p_in_vin_vs;
        trl_hs_drop = hs_word;
      end
      default: ;
    endcase
    if (take_word) begin
      if (line_full)      word_trunc = 1'b1;
      else if (!space_ok) word_ovf   = 1'b1;
      else                word_wr    = 1'b1;
    end
    trl_lost = trl_wr & fifo_full;
    fifo_wr  = word_wr | (trl_wr & ~fifo_full);
    if (trl_wr) begin
      fifo_wdata = make_trailer(frcnt, line_cnt, word_cnt, lovf_flag, trunc_flag, sec_cnt);
    end else begin
      fifo_wdata.sof  = sof_pend;
      fifo_wdata.eol  = 1'b0;
      fifo_wdata.data = p_in_vd;
    end
  end

  // Edge detectors, frame/line/word/second counters and sticky overflow
  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      vs_q        <= 1'b0;
      vs_low_seen <= 1'b0;
      syn_q       <= 1'b0;
      sec_cnt     <= '0;
      frcnt       <= '0;
      line_cnt    <= '0;
      word_cnt    <= '0;
      sof_pend    <= 1'b0;
      trunc_flag  <= 1'b0;
      lovf_flag   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vs_q  <= p_in_vin_vs;
      syn_q <= p_in_ext_syn;
      if (!p_in_vin_vs) vs_low_seen <= 1'b1;
      if (p_in_ext_syn & ~syn_q) sec_cnt <= sec_cnt + TRL_SEC_W'(1);
      if (frame_end) frcnt <= frcnt + 16'd1;
      if (frame_start) begin
        line_cnt   <= '0;
        word_cnt   <= '0;
        sof_pend   <= 1'b1;
        trunc_flag <= 1'b0;
        lovf_flag  <= 1'b0;
      end
      if (word_wr) begin
        word_cnt <= word_cnt + 16'd1;
        sof_pend <= 1'b0;
      end
      if (word_trunc) trunc_flag <= 1'b1;
      if (word_ovf)   lovf_flag  <= 1'b1;
      if (trl_wr) begin
        line_cnt   <= line_cnt + 16'd1;
        word_cnt   <= '0;
        lovf_flag  <= 1'b0;
        trunc_flag <= trl_hs_drop;
      end
      if (p_in_ovf_clr)             ovf_q <= 1'b0;
      else if (word_ovf | trl_lost) ovf_q <= 1'b1;
    end
  end

  vin_fifo_fwft #(
    .G_FIFO_AW (G_FIFO_AW)
  ) u_fifo (
    .clk   (p_in_clk),
    .rst   (p_in_rst),
    .wr    (fifo_wr),
    .wdata (fifo_wdata),
    .rd    (p_in_vd_rdy),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .free  (fifo_free)
  );

  assign p_out_vd     = fifo_rdata.data;
  assign p_out_vd_sof = fifo_rdata.sof;
  assign p_out_vd_eol = fifo_rdata.eol;
  assign p_out_vd_vld = ~fifo_empty;
  assign p_out_frcnt  = frcnt;
  assign p_out_ovf    = ovf_q;

endmodule

// File: tb/tb_vin_line_framer.sv
// Randomized scoreboard bench for vin_line_framer.
module tb_vin_line_framer;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LMAX  = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] vd  = '0;
  logic        vs  = 1'b0;
  logic        hs  = 1'b0;
  logic        syn = 1'b0;
  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;
  logic [79:0] out_vd;
  logic        vld;
  logic        sof;
  logic        eol;
  logic [15:0] frcnt;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vin_line_framer #(
    .G_FIFO_AW  (9),
    .G_LINE_MAX (LMAX)
  ) dut (
    .p_in_clk     (clk),
    .p_in_rst     (rst),
    .p_in_vd      (vd),
    .p_in_vin_vs  (vs),
    .p_in_vin_hs  (hs),
    .p_in_ext_syn (syn),
    .p_in_en      (en),
    .p_in_ovf_clr (clr),
    .p_out_vd     (out_vd),
    .p_out_vd_vld (vld),
    .p_in_vd_rdy  (rdy),
    .p_out_vd_sof (sof),
    .p_out_vd_eol (eol),
    .p_out_frcnt  (frcnt),
    .p_out_ovf    (ovf)
  );

  // Reference model: expected output stream plus per-line bookkeeping
  logic [81:0] exp_q[$];
  bit          m_active, m_sof, m_trunc, m_lovf, m_ovf, m_low_seen;
  bit          trl_due, prev_syn, clr_now, lat_chk;
  int          m_words;
  int          rdy_mode;
  int          clr_at = -1;
  logic [15:0] m_line, m_frcnt;
  logic [11:0] m_sec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // A data word offered to an enabled line
  function automatic void model_word(input logic [79:0] d);
    if (m_words >= int'(LMAX)) m_trunc = 1'b1;
    else if (exp_q.size() > int'(DEPTH) - 2) begin
      m_lovf = 1'b1;
      m_ovf  = 1'b1;
    end else begin
      exp_q.push_back({m_sof, 1'b0, d});
      m_sof = 1'b0;
      m_words++;
    end
  endfunction

  // End of a line: emit the status trailer
  function automatic void model_trailer();
    logic [79:0] t;
    t = {16'hA55A, m_frcnt, m_line, 16'(m_words), m_lovf, m_trunc, 2'b00, m_sec};
    if (exp_q.size() >= int'(DEPTH)) m_ovf = 1'b1;
    else exp_q.push_back({1'b0, 1'b1, t});
    m_line  = m_line + 16'd1;
    m_words = 0;
    m_lovf  = 1'b0;
    m_trunc = 1'b0;
  endfunction

  function automatic void frame_done();
    m_frcnt  = m_frcnt + 16'd1;
    m_active = 1'b0;
  endfunction

  // One clock of stimulus; pending trailer and second-pulse effects are modelled here
  task automatic tick(input bit v, input bit h, input logic [79:0] d);
    bit s;
    s = rst ? 1'b0 : ($urandom_range(0, 5) == 0);
    if (!rst) begin
      if (trl_due) begin
        model_trailer();
        trl_due = 1'b0;
        if (!v)     frame_done();
        else if (h) m_trunc = 1'b1;
      end
      if (s && !prev_syn) m_sec = m_sec + 12'd1;
      if (clr_now) m_ovf = 1'b0;
      if (!v) m_low_seen = 1'b1;
    end
    prev_syn = s;
    vs  = v;
    hs  = h;
    vd  = d;
    syn = s;
    clr = clr_now;
    if (rst || rdy_mode == 0) rdy = 1'b0;
    else if (rdy_mode == 1)   rdy = 1'b1;
    else                      rdy = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    clr_now = 1'b0;
  endtask

  function automatic logic [79:0] rand_word();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
  endtask

  task automatic frame_begin(input bit e);
    en = e;
    if (e && m_low_seen && !rst) begin
      m_active = 1'b1;
      m_line   = '0;
      m_sof    = 1'b1;
      m_words  = 0;
      m_trunc  = 1'b0;
      m_lovf   = 1'b0;
    end
    tick(1'b1, 1'b0, '0);
    en = 1'($urandom_range(0, 1));
    tick(1'b1, 1'b0, '0);
  endtask

  task automatic send_line(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      logic [79:0] d;
      d = rand_word();
      if (i == clr_at) clr_now = 1'b1;
      if (m_active && !trl_due) model_word(d);
      tick(1'b1, 1'b1, d);
      if (lat_chk && i == 0) begin
        chk("first_word_latency_vld", 64'(vld), 64'd1);
        chk("first_word_sof", 64'(sof), 64'd1);
        lat_chk = 1'b0;
      end
    end
    tick(1'b1, 1'b0, '0);
    if (m_active) trl_due = 1'b1;
    for (int g = 1; g < gap; g++) tick(1'b1, 1'b0, '0);
  endtask

  task automatic frame_end();
    if (!trl_due && m_active) frame_done();
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic line_vsfall(input int n);
    for (int i = 0; i < n; i++) begin
      logic [79:0] d;
      d = rand_word();
      if (m_active) model_word(d);
      tick(1'b1, 1'b1, d);
    end
    tick(1'b0, 1'b1, rand_word());
    if (m_active) trl_due = 1'b1;
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    int n;
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1'b0, 1'b0, '0);
      n++;
    end
    tick(1'b0, 1'b0, '0);
    chk("drain_pending_words", 64'(exp_q.size()), 64'd0);
    chk("drain_vld_low", 64'(vld), 64'd0);
  endtask

  task automatic do_reset(input int n, input bit v, input bit h);
    rst = 1'b1;
    exp_q.delete();
    m_active = 1'b0; m_sof = 1'b0; m_trunc = 1'b0; m_lovf = 1'b0; m_ovf = 1'b0;
    m_low_seen = 1'b0; trl_due = 1'b0; prev_syn = 1'b0; clr_now = 1'b0;
    m_words = 0; m_line = '0; m_frcnt = '0; m_sec = '0;
    for (int i = 0; i < n; i++) tick(v, h, rand_word());
    chk("reset_vld", 64'(vld), 64'd0);
    chk("reset_vd", 64'(out_vd[63:0]), 64'd0);
    chk("reset_sof_eol", 64'({sof, eol}), 64'd0);
    chk("reset_frcnt", 64'(frcnt), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
  endtask

  // Monitor: compare every transfer against the scoreboard, and hold stability while stalled
  logic [81:0] hold;
  bit          hold_v = 1'b0;
  always @(negedge clk) begin
    logic [81:0] act, exp;
    act = {sof, eol, out_vd};
    if (rst) hold_v = 1'b0;
    else if (vld) begin
      if (hold_v) begin
        checks++;
        if (act !== hold) begin
          errors++;
          $display("FAIL stall_hold actual=%h required=%h", act, hold);
        end
      end
      if (rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL out_word actual=%h required=%h", act, exp);
          end
        end
        hold_v = 1'b0;
      end else begin
        hold   = act;
        hold_v = 1'b1;
      end
    end else hold_v = 1'b0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy_mode = 1;
    do_reset(3, 1'b0, 1'b0);
    idle(3);

    // 3 lines x 4 words, always ready
    lat_chk = 1'b1;
    frame_begin(1'b1);
    for (int l = 0; l < 3; l++) send_line(4, 3);
    frame_end();
    idle(4);
    chk("frcnt_after_frame1", 64'(frcnt), 64'd1);
    chk("frcnt_model_frame1", 64'(frcnt), 64'(m_frcnt));

    // Over-long line is truncated without touching the sticky overflow
    rdy_mode = 2;
    frame_begin(1'b1);
    send_line(170, 2);
    frame_end();
    idle(3);
    chk("ovf_after_trunc", 64'(ovf), 64'd0);

    // Random frames, including back-to-back lines that hit the trailer cycle
    for (int f = 0; f < 4; f++) begin
      frame_begin(1'b1);
      for (int l = 0; l < int'($urandom_range(1, 4)); l++)
        send_line(int'($urandom_range(1, 200)), int'($urandom_range(1, 4)));
      frame_end();
      idle(int'($urandom_range(2, 5)));
      chk("frcnt_random_frame", 64'(frcnt), 64'(m_frcnt));
    end

    // vs falls mid-line after 5 words
    frame_begin(1'b1);
    send_line(3, 2);
    line_vsfall(5);
    idle(2);
    chk("frcnt_vsfall", 64'(frcnt), 64'(m_frcnt));
    drain();

    // Disabled frame produces nothing and is not counted
    frame_begin(1'b0);
    send_line(6, 2);
    send_line(6, 2);
    frame_end();
    idle(3);
    chk("disabled_no_output", 64'(vld), 64'd0);
    chk("disabled_frcnt", 64'(frcnt), 64'(m_frcnt));
    frame_begin(1'b1);
    send_line(7, 2);
    frame_end();
    idle(2);
    drain();

    // Stalled downstream fills the FIFO; clear collides with a drop once
    rdy_mode = 0;
    frame_begin(1'b1);
    for (int l = 0; l < 3; l++) send_line(160, 2);
    clr_at = 40;
    send_line(60, 2);
    clr_at = -1;
    frame_end();
    idle(2);
    chk("ovf_set_on_full", 64'(ovf), 64'd1);
    chk("ovf_model", 64'(ovf), 64'(m_ovf));
    drain();
    chk("ovf_sticky", 64'(ovf), 64'd1);
    clr_now = 1'b1;
    tick(1'b0, 1'b0, '0);
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // Reset in the middle of a line, then a clean frame
    rdy_mode = 2;
    frame_begin(1'b1);
    send_line(20, 2);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, rand_word());
    do_reset(3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, rand_word());
    tick(1'b1, 1'b0, '0);
    idle(3);
    chk("no_output_after_reset", 64'(vld), 64'd0);
    frame_begin(1'b1);
    send_line(5, 2);
    send_line(9, 1);
    send_line(3, 2);
    frame_end();
    idle(2);
    chk("frcnt_after_reset_frame", 64'(frcnt), 64'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
